subtractor_decomposable_seq: RTL and testbench
==============================================

// Module: subtractor_decomposable_seq
// PURPOSE
//  Multi-cycle, precision-decomposable unsigned subtractor; counterpart of the decomposable adder
//  in the posit datapath. Computes in0 - in1 one EACH_SUB_LEN lane per cycle with a registered borrow.
//  The borrow chain breaks at lane boundaries according to mode (8B / 16B / 32B).
//  Used by the posit exponent/fraction-alignment path; valid/ready handshake on both sides.
// PARAMETERS
//  EACH_SUB_LEN  8  width of one lane (bits)
//  N_SUBS        4  number of lanes; half/full packing is fixed for 4 (elaboration error otherwise)
// PORTS
//  clk        in   1                           clock, rising edge
//  rst_n      in   1                           asynchronous reset, active-low
//  in_valid   in   1                           operands/mode valid
//  in_ready   out  1                           block accepts a new operation
//  in0        in   EACH_SUB_LEN*N_SUBS         minuend (lane i = bits [i*LEN +: LEN])
//  in1        in   EACH_SUB_LEN*N_SUBS         subtrahend
//  mode       in   PRECISION_CONFIG_L          pe_pkg precision config
//  out_valid  out  1                           result valid
//  out_ready  in   1                           consumer accepts result
//  out_quart  out  [N_SUBS-1:0][LEN:0]         per-lane {borrow_out, diff}
//  out_half   out  [1:0][2*LEN:0]              {out_quart[2h+1], out_quart[2h][LEN-1:0]}
//  out_full   out  [4*LEN:0]                   {out_quart[3], q[2][LEN-1:0], q[1][LEN-1:0], q[0][LEN-1:0]}
// BEHAVIOUR
//  - FSM states IDLE, BUSY, DONE. Reset: IDLE, lane counter 0, borrow reg 0, result regs 0
//    (out_quart/out_half/out_full all 0), out_valid 0, in_ready 1.
//  - in_ready = (state==IDLE); out_valid = (state==DONE); both decoded from state only.
//  - IDLE: in_valid & in_ready at edge t -> capture in0, in1, mode; cnt=0; -> BUSY.
//  - BUSY: each edge computes lane cnt: {b_out, d} = {1'b0,a_cnt} - {1'b0,b_cnt} - b_in,
//    with b_out=1 iff a_cnt < b_cnt + b_in. Writes out_quart[cnt] = {b_out, d}; borrow reg <= b_out.
//    b_in = 0 for lane 0; 16B: b_in = 0 for lane 2; 8B: b_in = 0 for every lane; otherwise
//    (32B or any unlisted mode code) b_in = borrow from lane cnt-1.
//  - Lane N_SUBS-1 is written at edge t+N_SUBS; the same edge moves to DONE. Latency = N_SUBS cycles.
//  - DONE: results held stable; out_valid & out_ready -> IDLE. No accept in DONE (throughput 1 op
//    per N_SUBS+2 cycles minimum). in_valid while not IDLE is ignored; inputs need not stay stable.
//  - Captured mode is used for the whole op; mode changes after accept have no effect.
//  - Result regs of lanes not yet computed keep the previous op's values until overwritten;
//    only DONE outputs are valid.
//  - Wrap-around: unsigned modulo-2^w per segment; segment borrow = MSB of its packed output.
//  - rst_n low at any time (incl. BUSY/DONE) -> immediate reset state; the pending op is lost.
// STRUCTURE
//  - Use pe_pkg::PRECISION_CONFIG_8B/_16B/_32B and PRECISION_CONFIG_L; add the FSM state enum
//    (sub_state_t) to pe_pkg.
//  - One sub-module: subtractor_building_block #(LEN) (in0, in1, borrow_in -> out[LEN:0],
//    borrow_out), combinational, instantiated once and time-multiplexed over lanes.
//  - Borrow-break logic is a combinational function of captured mode and cnt.
// TESTING
//  1. 32B: in0=32'h0000_0100, in1=32'h0000_0001 -> out_valid 4 cycles after accept,
//     out_full=33'h0_0000_00FF.
//  2. 8B: in0=32'h0102_0304, in1=32'h0201_0405 -> out_quart = {9'h1FF, 9'h001, 9'h1FF, 9'h1FF}
//     (lane3..0); no borrow crosses lanes.
//  3. 16B: in0=32'h0, in1=32'h0001_0001 -> out_half[1]=out_half[0]=17'h1_FFFF
//     (lane1 borrow not fed into lane2).
//  4. 32B wrap: 0-1 -> out_full=33'h1_FFFF_FFFF; in0=in1=32'hDEAD_BEEF -> 33'h0.
//  5. Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid/in0 ->
//     outputs stable, in_ready=0; single out_ready pulse -> IDLE next cycle.
//  6. Reset: assert rst_n=0 in BUSY (cnt=2) -> all outputs 0, in_ready=1 asynchronously;
//     after release, test 1 passes unchanged.

Source files
------------

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkg
// Purpose  : Shared precision-config codes and subtractor FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int PRECISION_CONFIG_L = 2;

    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd0;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage
`default_nettype wire

// File: rtl/subtractor_building_block.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_building_block
// Purpose  : One-lane combinational subtractor; out = {borrow_out, difference}.
// Revision : 1.0 - initial release
// ============================================================================
module subtractor_building_block #(
    parameter int LEN = 8
) (
    input  logic [LEN-1:0] in0,
    input  logic [LEN-1:0] in1,
    input  logic           borrow_in,
    output logic [LEN:0]   out,
    output logic           borrow_out
);

    logic [LEN:0] w_diff;

    // The extra MSB of the widened difference is exactly the borrow out.
    assign w_diff     = {1'b0, in0} - {1'b0, in1} - {{LEN{1'b0}}, borrow_in};
    assign out        = w_diff;
    assign borrow_out = w_diff[LEN];

endmodule
`default_nettype wire

// File: rtl/subtractor_decomposable_seq.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_decomposable_seq
// Purpose  : Multi-cycle lane-serial unsigned subtractor with 8B/16B/32B borrow breaks.
// Revision : 1.0 - initial release
// ============================================================================
module subtractor_decomposable_seq
    import pe_pkg::*;
#(
    parameter int EACH_SUB_LEN = 8,
    parameter int N_SUBS       = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [EACH_SUB_LEN*N_SUBS-1:0]          in0,
    input  logic [EACH_SUB_LEN*N_SUBS-1:0]          in1,
    input  logic [PRECISION_CONFIG_L-1:0]           mode,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [N_SUBS-1:0][EACH_SUB_LEN:0]       out_quart,
    output logic [1:0][2*EACH_SUB_LEN:0]            out_half,
    output logic [4*EACH_SUB_LEN:0]                 out_full
);

    localparam int c_tot_w = EACH_SUB_LEN * N_SUBS;
    localparam int c_cnt_w = (N_SUBS > 1) ? $clog2(N_SUBS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_lane = c_cnt_w'(N_SUBS - 1);
    localparam logic [c_cnt_w-1:0] c_upper_half = c_cnt_w'(N_SUBS / 2);

    generate
        if (N_SUBS != 4) begin : g_bad_n_subs
            $error("subtractor_decomposable_seq: N_SUBS must be 4");
        end
    endgenerate

    sub_state_t                         r_state;
    sub_state_t                         w_next_state;
    logic [c_cnt_w-1:0]                 r_cnt;
    logic [c_tot_w-1:0]                 r_a;
    logic [c_tot_w-1:0]                 r_b;
    logic [PRECISION_CONFIG_L-1:0]      r_mode;
    logic                               r_borrow;
    logic [N_SUBS-1:0][EACH_SUB_LEN:0]  r_quart;

    logic                               w_borrow_in;
    logic [EACH_SUB_LEN:0]              w_lane_out;
    logic                               w_lane_borrow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)            w_next_state = BUSY;
            BUSY:    if (r_cnt == c_last_lane) w_next_state = DONE;
            DONE:    if (out_ready)           w_next_state = IDLE;
            default:                          w_next_state = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    // Lane 0 never takes a borrow; 8B breaks every lane, 16B breaks at the upper half.
    always_comb begin
        w_borrow_in = r_borrow;
        if (r_cnt == '0) begin
            w_borrow_in = 1'b0;
        end else begin
            case (r_mode)
                PRECISION_CONFIG_8B:  w_borrow_in = 1'b0;
                PRECISION_CONFIG_16B: if (r_cnt == c_upper_half) w_borrow_in = 1'b0;
                default:              w_borrow_in = r_borrow;
            endcase
        end
    end

    subtractor_building_block #(
        .LEN (EACH_SUB_LEN)
    ) u_lane (
        .in0        (r_a[r_cnt*EACH_SUB_LEN +: EACH_SUB_LEN]),
        .in1        (r_b[r_cnt*EACH_SUB_LEN +: EACH_SUB_LEN]),
        .borrow_in  (w_borrow_in),
        .out        (w_lane_out),
        .borrow_out (w_lane_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= '0;
            r_borrow <= 1'b0;
            r_quart  <= '0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_a    <= in0;
                r_b    <= in1;
                r_mode <= mode;
                r_cnt  <= '0;
            end else if (r_state == BUSY) begin
                r_quart[r_cnt] <= w_lane_out;
                r_borrow       <= w_lane_borrow;
                r_cnt          <= r_cnt + 1'b1;
            end
        end
    end

    assign out_quart = r_quart;

    generate
        for (genvar h = 0; h < 2; h++) begin : g_half
            assign out_half[h] = {r_quart[2*h+1], r_quart[2*h][EACH_SUB_LEN-1:0]};
        end
    endgenerate

    assign out_full = {r_quart[3],
                       r_quart[2][EACH_SUB_LEN-1:0],
                       r_quart[1][EACH_SUB_LEN-1:0],
                       r_quart[0][EACH_SUB_LEN-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_subtractor_decomposable_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtractor_decomposable_seq
// Purpose  : Scoreboard-based self-checking bench for subtractor_decomposable_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subtractor_decomposable_seq;
    import pe_pkg::*;

    typedef logic [3:0][8:0] quart_t;

    logic                           clk;
    logic                           rst_n;
    logic                           in_valid;
    logic                           in_ready;
    logic [31:0]                    in0;
    logic [31:0]                    in1;
    logic [PRECISION_CONFIG_L-1:0]  mode;
    logic                           out_valid;
    logic                           out_ready;
    logic [3:0][8:0]                out_quart;
    logic [1:0][16:0]               out_half;
    logic [32:0]                    out_full;

    int     n_tests;
    int     n_fail;
    quart_t sb_q[$];

    subtractor_decomposable_seq #(
        .EACH_SUB_LEN (8),
        .N_SUBS       (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quart (out_quart),
        .out_half  (out_half),
        .out_full  (out_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment-wide reference: each lane is the top slice of a wide subtraction
    // spanning from its segment start up to that lane.
    function automatic quart_t model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] m);
        quart_t q;
        for (int i = 0; i < 4; i++) begin
            int s;
            int n;
            logic [63:0] am, bm, x;
            if (m == PRECISION_CONFIG_8B)       s = i;
            else if (m == PRECISION_CONFIG_16B) s = (i >= 2) ? 2 : 0;
            else                                s = 0;
            n  = (i + 1 - s) * 8;
            am = (64'(a) >> (s * 8)) & ((64'd1 << n) - 64'd1);
            bm = (64'(b) >> (s * 8)) & ((64'd1 << n) - 64'd1);
            x  = am - bm;
            q[i] = {(am < bm), 8'(x >> ((i - s) * 8))};
        end
        return q;
    endfunction

    task automatic push_and_accept(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] m, input bit push);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        if (push) sb_q.push_back(model(a, b, m));
        in0 = a; in1 = b; mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in0 = $urandom; in1 = $urandom; mode = 2'($urandom_range(0, 3));
    endtask

    // Checks latency, pops the scoreboard at DONE, optionally holds backpressure, then drains.
    task automatic collect(input int hold);
        quart_t     e;
        logic [32:0] held;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL early_valid: cycle %0d out_valid=%b required 0", k, out_valid);
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: out_valid=%b required 1 at 4 cycles", out_valid);
        end
        if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_empty: size 0 required >0");
            return;
        end
        e = sb_q.pop_front();
        n_tests++;
        if (out_quart !== e) begin
            n_fail++;
            $display("FAIL out_quart: got %h required %h", out_quart, e);
        end
        n_tests++;
        if (out_half !== {e[3], e[2][7:0], e[1], e[0][7:0]}) begin
            n_fail++;
            $display("FAIL out_half: got %h required %h", out_half,
                     {e[3], e[2][7:0], e[1], e[0][7:0]});
        end
        n_tests++;
        if (out_full !== {e[3], e[2][7:0], e[1][7:0], e[0][7:0]}) begin
            n_fail++;
            $display("FAIL out_full: got %h required %h", out_full,
                     {e[3], e[2][7:0], e[1][7:0], e[0][7:0]});
        end
        held = {e[3], e[2][7:0], e[1][7:0], e[0][7:0]};
        for (int k = 0; k < hold; k++) begin
            in_valid = k[0]; in0 = $urandom; in1 = $urandom;
            @(posedge clk); #1;
            n_tests++;
            if (out_full !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stable: full=%h in_ready=%b out_valid=%b required %h 0 1",
                         out_full, in_ready, out_valid, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_quart !== '0 ||
            out_half !== '0 || out_full !== '0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b full=%h required 1 0 0",
                     in_ready, out_valid, out_full);
        end
    endtask

    task automatic test_32b_basic();
        push_and_accept(32'h0000_0100, 32'h0000_0001, PRECISION_CONFIG_32B, 1'b1);
        collect(0);
        n_tests++;
        if (out_full !== 33'h0_0000_00FF) begin
            n_fail++;
            $display("FAIL t1_full_const: got %h required 0000000ff", out_full);
        end
    endtask

    task automatic test_8b();
        push_and_accept(32'h0102_0304, 32'h0201_0405, PRECISION_CONFIG_8B, 1'b1);
        collect(0);
        n_tests++;
        if (out_quart !== {9'h1FF, 9'h001, 9'h1FF, 9'h1FF}) begin
            n_fail++;
            $display("FAIL t2_quart_const: got %h required 1ff 001 1ff 1ff", out_quart);
        end
    endtask

    task automatic test_16b();
        push_and_accept(32'h0000_0000, 32'h0001_0001, PRECISION_CONFIG_16B, 1'b1);
        collect(0);
        n_tests++;
        if (out_half[1] !== 17'h1_FFFF || out_half[0] !== 17'h1_FFFF) begin
            n_fail++;
            $display("FAIL t3_half_const: got %h %h required 1ffff 1ffff", out_half[1], out_half[0]);
        end
    endtask

    task automatic test_wrap();
        push_and_accept(32'h0, 32'h1, PRECISION_CONFIG_32B, 1'b1);
        collect(0);
        n_tests++;
        if (out_full !== 33'h1_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL t4_wrap: got %h required 1ffffffff", out_full);
        end
        push_and_accept(32'hDEAD_BEEF, 32'hDEAD_BEEF, PRECISION_CONFIG_32B, 1'b1);
        collect(0);
        n_tests++;
        if (out_full !== 33'h0) begin
            n_fail++;
            $display("FAIL t4_equal: got %h required 0", out_full);
        end
    endtask

    task automatic test_backpressure();
        push_and_accept(32'h8000_0000, 32'h0000_0001, PRECISION_CONFIG_16B, 1'b1);
        collect(10);
    endtask

    task automatic test_reset_busy();
        push_and_accept(32'h1234_5678, 32'h0000_0001, PRECISION_CONFIG_32B, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_quart !== '0 || out_full !== '0) begin
            n_fail++;
            $display("FAIL reset_busy: in_ready=%b out_valid=%b full=%h required 1 0 0",
                     in_ready, out_valid, out_full);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_32b_basic();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        for (int n = 0; n < 8; n++) begin
            a = $urandom;
            b = $urandom;
            push_and_accept(a, b, 2'(n % 4), 1'b1);
            collect(0);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in0       = '0;
        in1       = '0;
        mode      = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_32b_basic();
        test_8b();
        test_16b();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
